bayer_pattern_src: RTL and testbench

- Synthetic camera-side source for the image pipeline.
- Produces the raster pixel stream the image processor consumes: 12-bit raw Bayer samples, pixel coordinates and a data-valid strobe, with line and frame blanking.
- Replaces the sensor capture path during bring-up and simulation, so greyscale and convolution output can be checked against known patterns.

---
 rtl/imgproc_pkg.sv | 10 +
 rtl/bayer_pattern_src_if.sv | 21 ++
 rtl/bayer_pattern_value.sv | 16 +
 rtl/bayer_pattern_src.sv | 112 +++++++++++
 tb/tb_bayer_pattern_src.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/imgproc_pkg.sv
// imgproc_pkg: shared pattern modes, source FSM states and pixel level constants
package imgproc_pkg;
  typedef enum logic [1:0] {BAYER_FLAT, HRAMP, VRAMP, CHECKER} patMode_e;
  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} srcState_e;
  localparam logic [11:0] BAYER_G = 12'h800;
  localparam logic [11:0] BAYER_R = 12'hFFF;
  localparam logic [11:0] BAYER_B = 12'h000;
  localparam logic [11:0] CHECK_HI = 12'hFFF;
  localparam logic [11:0] CHECK_LO = 12'h000;
endpackage

// File: rtl/bayer_pattern_src_if.sv
// bayer_pattern_src_if: control inputs and raster pixel stream of the synthetic source
interface bayer_pattern_src_if;
  logic iSTART;
  logic iSTOP;
  logic [1:0] iMODE;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic [11:0] oDATA;
  logic oDVAL;
  logic oFVAL;
  logic oFRAME_DONE;
  logic [15:0] oFrame_Cont;
  modport master (
    input iSTART, iSTOP, iMODE,
    output oX_Cont, oY_Cont, oDATA, oDVAL, oFVAL, oFRAME_DONE, oFrame_Cont
  );
  modport slave (
    output iSTART, iSTOP, iMODE,
    input oX_Cont, oY_Cont, oDATA, oDVAL, oFVAL, oFRAME_DONE, oFrame_Cont
  );
endinterface

// File: rtl/bayer_pattern_value.sv
// bayer_pattern_value: maps pattern mode and pixel coordinates to a 12-bit raw sample
module bayer_pattern_value
  import imgproc_pkg::*;
(
  input patMode_e mode,
  input logic [10:0] x,
  input logic [10:0] y,
  output logic [11:0] pix
);
  // G R / B G cell for flat Bayer, ramps from the coordinates, 8x8 checker blocks
  always_comb
    pix = mode == BAYER_FLAT ? (y[0] ? (x[0] ? BAYER_G : BAYER_B) : (x[0] ? BAYER_R : BAYER_G)) :
          mode == HRAMP ? {x, 1'b0} :
          mode == VRAMP ? {y, 1'b0} :
          ((x[3] ^ y[3]) ? CHECK_HI : CHECK_LO);
endmodule

// File: rtl/bayer_pattern_src.sv
// bayer_pattern_src: raster timing FSM producing framed Bayer test patterns
module bayer_pattern_src
  import imgproc_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 4
) (
  input logic iCLK,
  input logic iRST,
  bayer_pattern_src_if.master bus
);
  localparam int LINE = H_ACTIVE + H_BLANK;
  localparam int CW = $clog2(LINE);
  localparam int LW = $clog2(V_BLANK + 1);
  localparam int HW = $clog2(H_BLANK + 1);
  localparam logic [10:0] xLast = 11'(H_ACTIVE - 1);
  localparam logic [10:0] yLast = 11'(V_ACTIVE - 1);
  localparam logic [HW-1:0] hLast = HW'(H_BLANK - 1);
  localparam logic [CW-1:0] cLast = CW'(LINE - 1);
  localparam logic [LW-1:0] lLast = LW'(V_BLANK - 1);
  srcState_e state;
  patMode_e modeLat, patMode;
  logic stopPending;
  logic [HW-1:0] hCnt;
  logic [CW-1:0] vCyc;
  logic [LW-1:0] vLine;
  logic [10:0] patX, patY;
  logic [11:0] patPix;
  // coordinates and mode of the pixel that would be emitted next cycle
  always_comb begin
    patMode = (state == IDLE || state == VBLANK) ? patMode_e'(bus.iMODE) : modeLat;
    patX = state == ACTIVE ? bus.oX_Cont + 11'd1 : '0;
    patY = state == HBLANK ? bus.oY_Cont + 11'd1 : state == ACTIVE ? bus.oY_Cont : '0;
  end
  bayer_pattern_value u_value (.mode(patMode), .x(patX), .y(patY), .pix(patPix));
  // raster FSM with registered pixel, strobe and frame outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      modeLat <= BAYER_FLAT;
      stopPending <= 1'b0;
      hCnt <= '0;
      vCyc <= '0;
      vLine <= '0;
      bus.oX_Cont <= '0;
      bus.oY_Cont <= '0;
      bus.oDATA <= '0;
      bus.oDVAL <= 1'b0;
      bus.oFVAL <= 1'b0;
      bus.oFRAME_DONE <= 1'b0;
      bus.oFrame_Cont <= '0;
    end else begin
      bus.oFRAME_DONE <= 1'b0;
      if (bus.iSTOP && state != IDLE) stopPending <= 1'b1;
      case (state)
        IDLE: if (bus.iSTART && !bus.iSTOP) begin
          state <= ACTIVE;
          modeLat <= patMode;
          bus.oX_Cont <= patX;
          bus.oY_Cont <= patY;
          bus.oDATA <= patPix;
          bus.oDVAL <= 1'b1;
          bus.oFVAL <= 1'b1;
        end
        ACTIVE: if (bus.oX_Cont == xLast) begin
          bus.oDVAL <= 1'b0;
          bus.oDATA <= '0;
          hCnt <= '0;
          vCyc <= '0;
          vLine <= '0;
          if (bus.oY_Cont == yLast) begin
            state <= VBLANK;
            bus.oFVAL <= 1'b0;
            bus.oFRAME_DONE <= 1'b1;
            bus.oFrame_Cont <= bus.oFrame_Cont + 16'd1;
          end else state <= HBLANK;
        end else begin
          bus.oX_Cont <= patX;
          bus.oDATA <= patPix;
        end
        HBLANK: if (hCnt == hLast) begin
          state <= ACTIVE;
          bus.oX_Cont <= patX;
          bus.oY_Cont <= patY;
          bus.oDATA <= patPix;
          bus.oDVAL <= 1'b1;
        end else hCnt <= hCnt + HW'(1);
        VBLANK: if (vCyc == cLast) begin
          vCyc <= '0;
          vLine <= vLine + LW'(1);
          if (vLine == lLast) begin
            if (stopPending || bus.iSTOP) begin
              state <= IDLE;
              stopPending <= 1'b0;
            end else begin
              state <= ACTIVE;
              modeLat <= patMode;
              bus.oX_Cont <= patX;
              bus.oY_Cont <= patY;
              bus.oDATA <= patPix;
              bus.oDVAL <= 1'b1;
              bus.oFVAL <= 1'b1;
            end
          end
        end else vCyc <= vCyc + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bayer_pattern_src.sv
// tb_bayer_pattern_src: scoreboard bench for the synthetic Bayer source on a 4x2 raster
module tb_bayer_pattern_src;
  localparam int HA = 4, VA = 2, HB = 2, VB = 1;
  localparam int LINE = HA + HB;
  localparam int PERIOD = VA * HA + (VA - 1) * HB + VB * LINE;
  typedef struct packed {logic [10:0] x; logic [10:0] y; logic [11:0] d; logic [19:0] c;} pix_t;
  typedef struct packed {logic [19:0] c; logic [15:0] cnt;} done_t;
  typedef struct {logic [1:0] mode; logic [11:0] row[2][4];} vec_t;
  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int cyc = 0;
  int nChk = 0, nFail = 0, expCnt = 0;
  int s;
  pix_t pixQ[$];
  done_t doneQ[$];
  vec_t tbl[4];
  bayer_pattern_src_if bus();
  bayer_pattern_src #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .iCLK(iCLK), .iRST(iRST), .bus(bus));
  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic pushPix(input int idx, input int x, input int y, input int st);
    pixQ.push_back('{x: 11'(x), y: 11'(y), d: tbl[idx].row[y][x], c: 20'(st + y * LINE + x)});
  endtask
  task automatic pushFrame(input int idx, input int st);
    for (int y = 0; y < VA; y++) for (int x = 0; x < HA; x++) pushPix(idx, x, y, st);
    expCnt++;
    doneQ.push_back('{c: 20'(st + VA * HA + (VA - 1) * HB), cnt: 16'(expCnt)});
  endtask
  task automatic drive(input logic start, input logic stop, input logic [1:0] mode);
    @(negedge iCLK);
    bus.iSTART = start;
    bus.iSTOP = stop;
    bus.iMODE = mode;
  endtask
  task automatic release_in();
    @(negedge iCLK);
    bus.iSTART = 1'b0;
    bus.iSTOP = 1'b0;
  endtask
  task automatic pulseStop();
    @(negedge iCLK);
    bus.iSTOP = 1'b1;
    @(negedge iCLK);
    bus.iSTOP = 1'b0;
  endtask
  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge iCLK);
  endtask
  task automatic chkOutputsZero(input string name);
    chk(name, {bus.oX_Cont, bus.oY_Cont, bus.oDATA, bus.oDVAL, bus.oFVAL, bus.oFRAME_DONE, bus.oFrame_Cont}, '0);
  endtask
  // scoreboard: every valid pixel and frame-done pulse must match the next expected entry
  always @(negedge iCLK) begin
    pix_t e;
    done_t d;
    if (bus.oDVAL) begin
      if (pixQ.size() == 0) begin
        nChk++;
        nFail++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d data=%0h at cycle %0d, required none", bus.oX_Cont, bus.oY_Cont, bus.oDATA, cyc);
      end else begin
        e = pixQ.pop_front();
        chk("pixel{x,y,data,cycle}", {bus.oX_Cont, bus.oY_Cont, bus.oDATA, 20'(cyc)}, 64'(e));
        chk("fval_with_dval", 64'(bus.oFVAL), 64'd1);
      end
    end else chk("data_zero_when_blank", 64'(bus.oDATA), 64'd0);
    if (bus.oFRAME_DONE) begin
      if (doneQ.size() == 0) begin
        nChk++;
        nFail++;
        $display("FAIL unexpected_frame_done: got pulse at cycle %0d count %0d, required none", cyc, bus.oFrame_Cont);
      end else begin
        d = doneQ.pop_front();
        chk("frame_done{cycle,count}", {20'(cyc), bus.oFrame_Cont}, 64'(d));
        chk("fval_low_at_done", 64'(bus.oFVAL), 64'd0);
      end
    end
  end
  initial begin
    tbl[0].mode = 2'd0;
    tbl[0].row = '{'{12'h800, 12'hFFF, 12'h800, 12'hFFF}, '{12'h000, 12'h800, 12'h000, 12'h800}};
    tbl[1].mode = 2'd1;
    tbl[1].row = '{'{12'h000, 12'h002, 12'h004, 12'h006}, '{12'h000, 12'h002, 12'h004, 12'h006}};
    tbl[2].mode = 2'd2;
    tbl[2].row = '{'{12'h000, 12'h000, 12'h000, 12'h000}, '{12'h002, 12'h002, 12'h002, 12'h002}};
    tbl[3].mode = 2'd3;
    tbl[3].row = '{'{12'h000, 12'h000, 12'h000, 12'h000}, '{12'h000, 12'h000, 12'h000, 12'h000}};
    bus.iSTART = 1'b0;
    bus.iSTOP = 1'b0;
    bus.iMODE = 2'd0;
    repeat (3) @(negedge iCLK);
    chkOutputsZero("reset_outputs");
    iRST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, tbl[i].mode);
      s = cyc + 1;
      pushFrame(i, s);
      release_in();
      pulseStop();
      waitUntil(s + PERIOD + 4);
      chk("stop_frame_count", 64'(bus.oFrame_Cont), 64'(expCnt));
      chk("stop_idle_dval", 64'(bus.oDVAL), 64'd0);
      chk("stop_pending_expect", 64'(pixQ.size() + doneQ.size()), 64'd0);
    end
    drive(1'b1, 1'b0, 2'd1);
    s = cyc + 1;
    for (int k = 0; k < 3; k++) pushFrame(1, s + k * PERIOD);
    release_in();
    waitUntil(s + 2 * PERIOD + 1);
    pulseStop();
    waitUntil(s + 3 * PERIOD + 4);
    chk("continuous_count", 64'(bus.oFrame_Cont), 64'(expCnt));
    chk("continuous_pending_expect", 64'(pixQ.size() + doneQ.size()), 64'd0);
    drive(1'b1, 1'b0, 2'd1);
    s = cyc + 1;
    pushFrame(1, s);
    pushFrame(2, s + PERIOD);
    release_in();
    waitUntil(s + 3);
    bus.iMODE = 2'd2;
    waitUntil(s + PERIOD + 4);
    pulseStop();
    waitUntil(s + 2 * PERIOD + 4);
    bus.iMODE = 2'd0;
    chk("mode_change_pending_expect", 64'(pixQ.size() + doneQ.size()), 64'd0);
    drive(1'b1, 1'b1, 2'd0);
    release_in();
    repeat (20) @(negedge iCLK);
    chk("start_with_stop_dval", 64'(bus.oDVAL), 64'd0);
    chk("start_with_stop_count", 64'(bus.oFrame_Cont), 64'(expCnt));
    drive(1'b1, 1'b0, 2'd0);
    s = cyc + 1;
    pushFrame(0, s);
    release_in();
    drive(1'b1, 1'b0, 2'd3);
    release_in();
    pulseStop();
    waitUntil(s + PERIOD + 4);
    chk("start_while_active_pending_expect", 64'(pixQ.size() + doneQ.size()), 64'd0);
    drive(1'b1, 1'b0, 2'd1);
    s = cyc + 1;
    for (int k = 0; k < 7; k++) pushPix(1, k % HA, k / HA, s);
    release_in();
    waitUntil(s + LINE + 2);
    iRST = 1'b1;
    @(negedge iCLK);
    chkOutputsZero("mid_frame_reset_outputs");
    iRST = 1'b0;
    expCnt = 0;
    repeat (20) @(negedge iCLK);
    chk("mid_frame_reset_pending_expect", 64'(pixQ.size() + doneQ.size()), 64'd0);
    chk("mid_frame_reset_idle_dval", 64'(bus.oDVAL), 64'd0);
    drive(1'b1, 1'b0, 2'd0);
    s = cyc + 1;
    pushFrame(0, s);
    release_in();
    pulseStop();
    waitUntil(s + PERIOD + 4);
    chk("restart_count", 64'(bus.oFrame_Cont), 64'd1);
    chk("restart_pending_expect", 64'(pixQ.size() + doneQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
